// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multicycle IEEE-754 single-precision multiplier built on a 24-step shift-and-add significand core.
// Optional macro FP_MUL_RNE_EN selects round-to-nearest-even; without it the significand is truncated.
module fp_mul_seq #(
    parameter int XLEN   = 32,
    parameter int MANT_W = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            underflow,
    output logic            exception
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic signed [9:0]   exp_q, exp_d;
    logic [MANT_W-1:0]   mcand_q, mcand_d;
    logic [MANT_W-1:0]   acc_q, acc_d;
    logic [MANT_W-1:0]   mplr_q, mplr_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                exc_q, exc_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;

    logic                a_emax_s, b_emax_s, a_ezero_s, b_ezero_s, a_nan_s, b_nan_s;
    logic                op_sign_s;
    logic [MANT_W:0]     add_s;
    logic [22:0]         frac_s, frac_r_s;
    logic signed [9:0]   exp_n_s, exp_r_s;

    assign a_emax_s  = &A[30:23];
    assign b_emax_s  = &B[30:23];
    assign a_ezero_s = ~|A[30:23];
    assign b_ezero_s = ~|B[30:23];
    assign a_nan_s   = a_emax_s & (|A[22:0]);
    assign b_nan_s   = b_emax_s & (|B[22:0]);
    assign op_sign_s = A[31] ^ B[31];

    // Upper half of the {acc, mplr} product register absorbs the multiplicand when the multiplier LSB is set.
    assign add_s = mplr_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};

    // A product in [2,4) carries its leading one at bit 47 and bumps the exponent.
    assign frac_s  = acc_q[23] ? acc_q[22:0] : {acc_q[21:0], mplr_q[23]};
    assign exp_n_s = exp_q + $signed({9'd0, acc_q[23]});

`ifdef FP_MUL_RNE_EN
    logic        guard_s, sticky_s, rnd_s;
    logic [23:0] frac_inc_s;

    assign guard_s    = acc_q[23] ? mplr_q[23] : mplr_q[22];
    assign sticky_s   = acc_q[23] ? (|mplr_q[22:0]) : (|mplr_q[21:0]);
    assign rnd_s      = guard_s & (sticky_s | frac_s[0]);
    assign frac_inc_s = {1'b0, frac_s} + {23'd0, rnd_s};
    assign frac_r_s   = frac_inc_s[22:0];
    assign exp_r_s    = exp_n_s + $signed({9'd0, frac_inc_s[23]});
`else
    assign frac_r_s   = frac_s;
    assign exp_r_s    = exp_n_s;
`endif

    // Next-state and datapath control for the IDLE/MUL/NORM/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplr_d      = mplr_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        exc_d       = exc_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d = op_sign_s;
                    exp_d  = $signed({2'b00, A[30:23]}) + $signed({2'b00, B[30:23]}) - 10'sd127;
                    if (a_emax_s || b_emax_s) begin
                        exc_d    = 1'b1;
                        result_d = (a_nan_s || b_nan_s || a_ezero_s || b_ezero_s) ?
                                   32'h7FC0_0000 : {op_sign_s, 8'hFF, 23'd0};
                        state_d  = DONE;
                    end else if (a_ezero_s || b_ezero_s) begin
                        result_d = {op_sign_s, 31'd0};
                        state_d  = DONE;
                    end else begin
                        mcand_d = {1'b1, A[22:0]};
                        mplr_d  = {1'b1, B[22:0]};
                        acc_d   = {MANT_W{1'b0}};
                        cnt_d   = 5'd0;
                        state_d = MUL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d  = add_s[MANT_W:1];
                mplr_d = {add_s[0], mplr_q[MANT_W-1:1]};
                if (cnt_q == 5'(MANT_W - 1)) begin
                    cnt_d   = 5'd0;
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            NORM: begin
                if (exp_r_s >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (exp_r_s <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r_s[7:0], frac_r_s};
                end
                state_d = DONE;
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    exc_d       = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            sign_q      <= 1'b0;
            exp_q       <= 10'sd0;
            mcand_q     <= {MANT_W{1'b0}};
            acc_q       <= {MANT_W{1'b0}};
            mplr_q      <= {MANT_W{1'b0}};
            result_q    <= {XLEN{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            exc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplr_q      <= mplr_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            exc_q       <= exc_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign exception = exc_q;
endmodule
